// File: rtl/matrix_pair_loader_pkg.sv
// matrix_pair_loader_pkg: shared FSM state type and sizing helper for the matrix pair loader
package matrix_pair_loader_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, DONE, ERR} loader_state_t;
    function automatic int clog2_min1(input int v);
        return v > 1 ? $clog2(v) : 1;
    endfunction
endpackage

// File: rtl/matrix_pair_loader_elem_assembler.sv
// matrix_pair_loader_elem_assembler: packs IN_W-bit beats LSB-first into ELEM_W-bit elements
module matrix_pair_loader_elem_assembler
    import matrix_pair_loader_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int IN_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              beat,
    input  logic [IN_W-1:0]   data,
    output logic [ELEM_W-1:0] elem,
    output logic              elem_valid
);
    localparam int BPE = ELEM_W / IN_W;
    localparam int BW  = clog2_min1(BPE);
    logic [BW-1:0]     cnt;
    logic              last;
    logic [ELEM_W-1:0] shifted;
    assign last = cnt == BW'(BPE - 1);
    generate
        if (BPE == 1) begin : g_single
            assign shifted = data;
        end else begin : g_multi
            assign shifted = {data, elem[ELEM_W-1:IN_W]};
        end
    endgenerate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            elem       <= '0;
            elem_valid <= 1'b0;
        end else begin
            elem_valid <= beat && last;
            if (beat) begin
                cnt  <= last ? '0 : cnt + 1'b1;
                elem <= shifted;
            end else if (clr) begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/matrix_pair_loader.sv
// matrix_pair_loader: loads A by rows and B by columns from one beat stream and serves row/column reads
module matrix_pair_loader
    import matrix_pair_loader_pkg::*;
#(
    parameter int N       = 32,
    parameter int ELEM_W  = 8,
    parameter int IN_W    = 2,
    parameter int GAP_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  axiiv,
    input  logic [IN_W-1:0]       axiid,
    input  logic                  rd_en,
    input  logic [$clog2(N)-1:0]  req_a_row,
    input  logic [$clog2(N)-1:0]  req_b_col,
    output logic [$clog2(N)-1:0]  addr_out,
    output logic [N*ELEM_W-1:0]   a_row_out,
    output logic [N*ELEM_W-1:0]   b_col_out,
    output logic                  rd_valid,
    output logic                  complete,
    output logic                  err
);
    localparam int LN = $clog2(N);
    localparam int NN = N * N;
    localparam int EW = $clog2(2 * NN);
    localparam int GW = $clog2(GAP_MAX + 2);
    loader_state_t     state, state_n;
    logic [EW-1:0]     ecnt;
    logic [GW-1:0]     gap;
    logic              armed, loading, start, beat, gap_over, ev, rd_ok;
    logic [ELEM_W-1:0] elem;
    logic [LN-1:0]     ei, ej;
    logic [N*ELEM_W-1:0] a_row [N];
    logic [N*ELEM_W-1:0] b_col [N];
    assign loading  = state == LOAD_A || state == LOAD_B;
    assign start    = axiiv && (state == IDLE || (state == DONE && armed));
    assign gap_over = gap > GW'(GAP_MAX);
    assign beat     = start || (loading && axiiv && !gap_over);
    assign complete = state == DONE;
    assign rd_ok    = complete && !start;
    assign ei       = ecnt[2*LN-1:LN];
    assign ej       = ecnt[LN-1:0];
    matrix_pair_loader_elem_assembler #(.ELEM_W(ELEM_W), .IN_W(IN_W)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (!loading),
        .beat       (beat),
        .data       (axiid),
        .elem       (elem),
        .elem_valid (ev)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = axiiv ? LOAD_A : IDLE;
            LOAD_A:  state_n = gap_over ? ERR : (ev && ecnt == EW'(NN - 1)) ? LOAD_B : LOAD_A;
            LOAD_B:  state_n = gap_over ? ERR : (ev && ecnt == EW'(2 * NN - 1)) ? DONE : LOAD_B;
            DONE:    state_n = start ? LOAD_A : DONE;
            ERR:     state_n = axiiv ? ERR : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ecnt  <= '0;
            gap   <= '0;
            armed <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            ecnt  <= loading ? ecnt + EW'(ev) : '0;
            gap   <= (loading && !axiiv) ? gap + 1'b1 : '0;
            armed <= state == DONE && (armed || !axiiv);
            err   <= state_n == ERR ? 1'b1 : state_n == LOAD_A ? 1'b0 : err;
        end
    end
    // Top counter bit selects B; B lands transposed so a column is one word.
    always_ff @(posedge clk) begin
        if (ev && loading) begin
            if (!ecnt[EW-1]) a_row[ei][ej*ELEM_W +: ELEM_W] <= elem;
            else             b_col[ej][ei*ELEM_W +: ELEM_W] <= elem;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            addr_out  <= '0;
            a_row_out <= '0;
            b_col_out <= '0;
        end else begin
            rd_valid <= rd_en && rd_ok;
            if (rd_en && rd_ok) begin
                addr_out  <= req_a_row;
                a_row_out <= a_row[req_a_row];
                b_col_out <= b_col[req_b_col];
            end
        end
    end
endmodule

// File: tb/tb_matrix_pair_loader.sv
// tb_matrix_pair_loader: directed checks of a 4x4 loader and a default 32x32 loader
module tb_matrix_pair_loader;
    logic         clk = 1'b0;
    logic         rst, axiiv, rd_en, sel;
    logic [1:0]   axiid;
    logic [4:0]   req_a, req_b;
    logic [1:0]   addr_s;
    logic [31:0]  a_s, b_s;
    logic         rdv_s, cmp_s, err_s;
    logic [4:0]   addr_b;
    logic [255:0] a_b, b_b;
    logic         rdv_b, cmp_b, err_b;
    logic [255:0] a_m, b_m, addr_m;
    logic         rdv_m, cmp_m, err_m;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    matrix_pair_loader #(.N(4), .ELEM_W(8), .IN_W(2), .GAP_MAX(4)) u_small (
        .clk(clk), .rst(rst), .axiiv(axiiv && !sel), .axiid(axiid), .rd_en(rd_en),
        .req_a_row(req_a[1:0]), .req_b_col(req_b[1:0]), .addr_out(addr_s),
        .a_row_out(a_s), .b_col_out(b_s), .rd_valid(rdv_s), .complete(cmp_s), .err(err_s)
    );
    matrix_pair_loader u_big (
        .clk(clk), .rst(rst), .axiiv(axiiv && sel), .axiid(axiid), .rd_en(rd_en),
        .req_a_row(req_a), .req_b_col(req_b), .addr_out(addr_b),
        .a_row_out(a_b), .b_col_out(b_b), .rd_valid(rdv_b), .complete(cmp_b), .err(err_b)
    );
    assign a_m    = sel ? a_b : 256'(a_s);
    assign b_m    = sel ? b_b : 256'(b_s);
    assign addr_m = sel ? 256'(addr_b) : 256'(addr_s);
    assign rdv_m  = sel ? rdv_b : rdv_s;
    assign cmp_m  = sel ? cmp_b : cmp_s;
    assign err_m  = sel ? err_b : err_s;
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] elem_val(input int mode, input int e, input int n);
        int f;
        f = e % (n * n);
        if (mode == 0) return (f / n == f % n) ? 8'h00 : 8'hFF;
        if (mode == 1) return 8'(e);
        return 8'h11;
    endfunction
    task automatic send_stream(input int mode, input int gap_every, input int gap_len, input int stop_at);
        int n;
        logic [7:0] v;
        n = sel ? 32 : 4;
        for (int e = 0; e < 2 * n * n; e++) begin
            v = elem_val(mode, e, n);
            for (int b = 0; b < 4; b++) begin
                int k;
                k = e * 4 + b;
                if (k == stop_at) begin
                    @(negedge clk);
                    axiiv = 1'b0;
                    return;
                end
                if (gap_every > 0 && k > 0 && k % gap_every == 0)
                    repeat (gap_len) begin
                        @(negedge clk);
                        axiiv = 1'b0;
                    end
                @(negedge clk);
                axiiv = 1'b1;
                axiid = v[2*b +: 2];
                rd_en = k == 0;
                if (k == 0) begin
                    @(posedge clk);
                    #1;
                    check("start_rd_valid", 256'(rdv_m), 256'(0));
                    check("start_err", 256'(err_m), 256'(0));
                    check("start_complete", 256'(cmp_m), 256'(0));
                end
            end
        end
        @(negedge clk);
        axiiv = 1'b0;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        check("last_write_rd_valid", 256'(rdv_m), 256'(0));
        check("end_complete", 256'(cmp_m), 256'(1));
        @(negedge clk);
        rd_en = 1'b0;
    endtask
    task automatic do_read(input int r, input int c, input logic [255:0] ea, input logic [255:0] eb);
        @(negedge clk);
        rd_en = 1'b1;
        req_a = 5'(r);
        req_b = 5'(c);
        @(posedge clk);
        #1;
        check("rd_valid", 256'(rdv_m), 256'(1));
        check("a_row", a_m, ea);
        check("b_col", b_m, eb);
        check("addr", addr_m, 256'(r));
        @(negedge clk);
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        check("rd_valid_drop", 256'(rdv_m), 256'(0));
    endtask
    initial begin
        logic [255:0] x, y;
        sel = 1'b0; rst = 1'b1; axiiv = 1'b0; axiid = '0; rd_en = 1'b0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_valid", 256'(rdv_s), 256'(0));
        check("rst_complete", 256'(cmp_s), 256'(0));
        check("rst_err", 256'(err_s), 256'(0));
        check("rst_a_row", 256'(a_s), 256'(0));
        check("rst_addr", 256'(addr_s), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        send_stream(0, 0, 0, -1);
        do_read(2, 2, 256'h0000_0000_FF00_FFFF, 256'h0000_0000_FF00_FFFF);
        send_stream(1, 0, 0, -1);
        do_read(1, 3, 256'h0706_0504, 256'h1F1B_1713);
        send_stream(1, 10, 3, -1);
        do_read(1, 3, 256'h0706_0504, 256'h1F1B_1713);
        check("gap_ok_err", 256'(err_s), 256'(0));
        send_stream(1, 0, 0, 41);
        repeat (8) @(negedge clk);
        check("abort_err", 256'(err_s), 256'(1));
        check("abort_complete", 256'(cmp_s), 256'(0));
        rd_en = 1'b1; req_a = 5'd2; req_b = 5'd0;
        @(posedge clk);
        #1;
        check("abort_rd_valid", 256'(rdv_s), 256'(0));
        check("abort_hold", 256'(a_s), 256'h0706_0504);
        @(negedge clk);
        rd_en = 1'b0;
        send_stream(1, 0, 0, -1);
        check("recover_err", 256'(err_s), 256'(0));
        do_read(1, 3, 256'h0706_0504, 256'h1F1B_1713);
        send_stream(0, 0, 0, 60);
        rst = 1'b1;
        #2;
        check("midrst_complete", 256'(cmp_s), 256'(0));
        check("midrst_err", 256'(err_s), 256'(0));
        check("midrst_rd_valid", 256'(rdv_s), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_stream(1, 0, 0, -1);
        do_read(1, 3, 256'h0706_0504, 256'h1F1B_1713);
        do_read(3, 0, 256'h0F0E_0D0C, 256'h1C18_1410);
        sel = 1'b1;
        @(negedge clk);
        send_stream(0, 0, 0, -1);
        x = '1;
        x[7:0] = 8'h00;
        do_read(0, 0, x, x);
        x = '1;
        x[40 +: 8] = 8'h00;
        y = '1;
        y[56 +: 8] = 8'h00;
        do_read(5, 7, x, y);
        send_stream(2, 0, 0, -1);
        do_read(0, 0, {32{8'h11}}, {32{8'h11}});
        check("big_err", 256'(err_b), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
